seg7_count_display: RTL

- Downstream display stage for the 4-bit up/down counter with divided-clock output.
- Captures the counter value, direction and enable on each falling edge of the counter's divided clock.
- Converts the 4-bit value to two BCD digits.
- Time-multiplexes the result onto a 4-digit common-anode seven-segment display.

---
 rtl/seg7_count_display.sv | 87 ++++++++
 1 files changed

// File: rtl/seg7_count_display.sv
// seg7_count_display: captures counter value/direction/enable on the strobe's falling edge and scans it onto a 4-digit common-anode display.
// Define SEG7_LEADING_ZERO_BLANK_EN to blank the tens digit when it is zero.
module seg7_count_display #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int SCAN_HZ = 1000
) (
  input  logic       iClk,
  input  logic       iReset,
  input  logic [3:0] iValue,
  input  logic       iUp,
  input  logic       iEn,
  input  logic       iStrobe,
  output logic [6:0] oSeg,
  output logic [3:0] oAn,
  output logic [7:0] oBcd
);
  localparam int TICK = (CLK_HZ / SCAN_HZ) < 1 ? 1 : CLK_HZ / SCAN_HZ;
  localparam int CW = TICK > 1 ? $clog2(TICK) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK - 1);

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = 7'b1111111;
    endcase
  endfunction

  logic          s1, s2, s3;
  logic [3:0]    capVal;
  logic          capUp, capEn;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [3:0]    ones;
  logic          tens;
  logic [6:0]    tensSeg, modeSeg, segNext;

  always_comb begin
    tens = capVal > 4'd9;
    ones = tens ? capVal - 4'd10 : capVal;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    tensSeg = tens ? glyph({3'b000, tens}) : 7'b1111111;
`else
    tensSeg = glyph({3'b000, tens});
`endif
    modeSeg = !capEn ? 7'b0111111 : capUp ? 7'b1000001 : 7'b0100001;
    segNext = idx == 2'd0 ? glyph(ones) : idx == 2'd1 ? tensSeg : idx == 2'd2 ? 7'b1111111 : modeSeg;
  end

  assign oBcd = {3'b000, tens, ones};

  // Capture uses the synchronized strobe; display registers read pre-capture data on a coincident edge.
  always_ff @(posedge iClk or posedge iReset)
    if (iReset) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s3     <= 1'b0;
      capVal <= 4'd0;
      capUp  <= 1'b1;
      capEn  <= 1'b0;
      cnt    <= '0;
      idx    <= 2'd0;
      oAn    <= 4'b1111;
      oSeg   <= 7'b1111111;
    end else begin
      s1 <= iStrobe;
      s2 <= s1;
      s3 <= s2;
      if (s3 && !s2) begin
        capVal <= iValue;
        capUp  <= iUp;
        capEn  <= iEn;
      end
      cnt  <= cnt == LAST ? '0 : cnt + 1'b1;
      idx  <= cnt == LAST ? idx + 2'd1 : idx;
      oAn  <= ~(4'b0001 << idx);
      oSeg <= segNext;
    end
endmodule
